// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with tick strobe and boundary-synchronous divisor reload.
// Build option: define CLK_DIV_TICK_EN to generate tick_out; otherwise tick_out is tied low.
module clk_div_prog #(
    parameter int CNT_WIDTH = 8,
    parameter int RST_HALF  = 125
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_half,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 tick_out,
    output logic                 div_pend
);

    localparam logic [CNT_WIDTH-1:0] RST_HALF_C = CNT_WIDTH'(RST_HALF);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] half_q;
    logic [CNT_WIDTH-1:0] half_d;
    logic [CNT_WIDTH-1:0] shadow_q;
    logic [CNT_WIDTH-1:0] shadow_d;
    logic                 clk_q;
    logic                 clk_d;
    logic                 pend_q;
    logic                 pend_d;
    logic                 boundary_s;

    // The counter only ever climbs from zero to half_q, so equality marks the phase end.
    assign boundary_s = (cnt_q == half_q);

    // Half-period counter and square-wave level.
    always_comb begin
        cnt_d = cnt_q;
        clk_d = clk_q;
        if (!en) begin
            cnt_d = CNT_ZERO;
            clk_d = 1'b0;
        end else if (boundary_s) begin
            cnt_d = CNT_ZERO;
            clk_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            clk_d = clk_q;
        end
    end

    // Divisor update: commits only at a phase boundary (or while stopped) so no phase is cut short.
    always_comb begin
        half_d   = half_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (!en || boundary_s) begin
            if (div_load) begin
                half_d   = div_half;
                shadow_d = div_half;
            end else if (pend_q) begin
                half_d   = shadow_q;
            end else begin
                half_d   = half_q;
            end
            pend_d = 1'b0;
        end else if (div_load) begin
            shadow_d = div_half;
            pend_d   = 1'b1;
        end else begin
            pend_d   = pend_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q    <= CNT_ZERO;
            half_q   <= RST_HALF_C;
            shadow_q <= RST_HALF_C;
            clk_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            pend_q   <= pend_d;
        end
    end

    assign clk_out  = clk_q;
    assign div_pend = pend_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q;
    logic tick_d;

    // Tick fires on the same edge that raises clk_out.
    always_comb begin
        tick_d = en && boundary_s && !clk_q;
    end

    // Tick register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;
`else
    assign tick_out = 1'b0;
`endif

endmodule
